// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// Optional external interrupt support is enabled by TRAP_CTRL_EXT_IRQ_EN.
package trap_controller_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      CFLOW_NORMAL,
      CFLOW_ECALL,
      CFLOW_EBREAK,
      CFLOW_MRET
   } cflow_mode_t;

   typedef enum logic [1:0] {
      IDLE,
      FENCEI_WAIT,
      REDIRECT
   } trap_state_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [31:0] MCAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] MCAUSE_BREAK   = 32'd3;
   localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
   localparam logic [31:0] MCAUSE_EXT_IRQ = 32'h8000_000B;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MEIE     = 11;

endpackage

// File: rtl/trap_controller_if.sv
// Commit-side bundle between the pipeline and the trap controller.
// The irq_ext_i signal exists only when TRAP_CTRL_EXT_IRQ_EN is defined.
interface trap_controller_if
   import trap_controller_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            valid_i;
   logic [XLEN-1:0] pc_i;
   logic [31:0]     instr_i;
   cflow_mode_t     cflow_mode_i;
   logic            illegal_op_i;
   logic            fencei_i;
   logic            csr_we_i;
   logic [11:0]     csr_addr_i;
   logic [XLEN-1:0] csr_wdata_i;
   logic [XLEN-1:0] csr_rdata_o;
   logic            commit_kill_o;
   logic            stall_o;
   logic            redirect_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            icache_flush_req_o;
   logic            icache_flush_ack_i;
`ifdef TRAP_CTRL_EXT_IRQ_EN
   logic            irq_ext_i;

   modport master (
      output valid_i, pc_i, instr_i, cflow_mode_i, illegal_op_i, fencei_i,
      output csr_we_i, csr_addr_i, csr_wdata_i, icache_flush_ack_i, irq_ext_i,
      input  csr_rdata_o, commit_kill_o, stall_o, redirect_o, redirect_pc_o,
      input  icache_flush_req_o
   );
   modport slave (
      input  valid_i, pc_i, instr_i, cflow_mode_i, illegal_op_i, fencei_i,
      input  csr_we_i, csr_addr_i, csr_wdata_i, icache_flush_ack_i, irq_ext_i,
      output csr_rdata_o, commit_kill_o, stall_o, redirect_o, redirect_pc_o,
      output icache_flush_req_o
   );
`else
   modport master (
      output valid_i, pc_i, instr_i, cflow_mode_i, illegal_op_i, fencei_i,
      output csr_we_i, csr_addr_i, csr_wdata_i, icache_flush_ack_i,
      input  csr_rdata_o, commit_kill_o, stall_o, redirect_o, redirect_pc_o,
      input  icache_flush_req_o
   );
   modport slave (
      input  valid_i, pc_i, instr_i, cflow_mode_i, illegal_op_i, fencei_i,
      input  csr_we_i, csr_addr_i, csr_wdata_i, icache_flush_ack_i,
      output csr_rdata_o, commit_kill_o, stall_o, redirect_o, redirect_pc_o,
      output icache_flush_req_o
   );
`endif
endinterface

// File: rtl/trap_csr_file.sv
// Machine trap CSR storage, read mux and trap/MRET update port.
// TRAP_CTRL_EXT_IRQ_EN adds mie.MEIE and the read-only mip.MEIP view.
module trap_csr_file
   import trap_controller_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_MTVEC = 'h100
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_csr_we,
   input  logic [11:0]     i_csr_addr,
   input  logic [XLEN-1:0] i_csr_wdata,
   output logic [XLEN-1:0] o_csr_rdata,
   input  logic            i_trap,
   input  logic [XLEN-1:0] i_trap_epc,
   input  logic [XLEN-1:0] i_trap_cause,
   input  logic [XLEN-1:0] i_trap_tval,
   input  logic            i_mret,
`ifdef TRAP_CTRL_EXT_IRQ_EN
   input  logic            i_irq_ext,
   output logic            o_mie,
   output logic            o_meie,
`endif
   output logic [XLEN-1:0] o_mtvec,
   output logic [XLEN-1:0] o_mepc
);

   logic            r_mie;
   logic            r_mpie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_mtval;
`ifdef TRAP_CTRL_EXT_IRQ_EN
   logic            r_meie;
`endif

   // Trap/MRET updates come last so they override a same-cycle CSR write.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mie    <= 1'b0;
         r_mpie   <= 1'b0;
         r_mtvec  <= {RESET_MTVEC[XLEN-1:2], 2'b00};
         r_mepc   <= '0;
         r_mcause <= '0;
         r_mtval  <= '0;
`ifdef TRAP_CTRL_EXT_IRQ_EN
         r_meie   <= 1'b0;
`endif
      end else begin
         if (i_csr_we) begin
            case (i_csr_addr)
               CSR_MSTATUS: begin
                  r_mie  <= i_csr_wdata[MSTATUS_MIE];
                  r_mpie <= i_csr_wdata[MSTATUS_MPIE];
               end
               CSR_MTVEC:  r_mtvec  <= {i_csr_wdata[XLEN-1:2], 2'b00};
               CSR_MEPC:   r_mepc   <= {i_csr_wdata[XLEN-1:2], 2'b00};
               CSR_MCAUSE: r_mcause <= i_csr_wdata;
               CSR_MTVAL:  r_mtval  <= i_csr_wdata;
`ifdef TRAP_CTRL_EXT_IRQ_EN
               CSR_MIE:    r_meie   <= i_csr_wdata[MIE_MEIE];
`endif
               default: ;
            endcase
         end
         if (i_trap) begin
            r_mepc   <= i_trap_epc;
            r_mcause <= i_trap_cause;
            r_mtval  <= i_trap_tval;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
         end else if (i_mret) begin
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
         end
      end
   end

   always_comb begin
      o_csr_rdata = '0;
      case (i_csr_addr)
         CSR_MSTATUS: begin
            o_csr_rdata[MSTATUS_MIE]  = r_mie;
            o_csr_rdata[MSTATUS_MPIE] = r_mpie;
         end
         CSR_MTVEC:  o_csr_rdata = r_mtvec;
         CSR_MEPC:   o_csr_rdata = r_mepc;
         CSR_MCAUSE: o_csr_rdata = r_mcause;
         CSR_MTVAL:  o_csr_rdata = r_mtval;
`ifdef TRAP_CTRL_EXT_IRQ_EN
         CSR_MIE:    o_csr_rdata[MIE_MEIE] = r_meie;
         CSR_MIP:    o_csr_rdata[MIE_MEIE] = i_irq_ext;
`endif
         default: ;
      endcase
   end

   assign o_mtvec = r_mtvec;
   assign o_mepc  = r_mepc;
`ifdef TRAP_CTRL_EXT_IRQ_EN
   assign o_mie   = r_mie;
   assign o_meie  = r_meie;
`endif

endmodule

// File: rtl/trap_controller.sv
// Commit-stage trap, MRET and FENCE.I sequencer with PC redirect.
// Define TRAP_CTRL_EXT_IRQ_EN to take machine external interrupts.
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_MTVEC = 'h100
) (
   input  logic              clk,
   input  logic              reset,
   trap_controller_if.slave  bus
);

   trap_state_t     r_state;
   logic            r_redirect;
   logic            r_flush_req;
   logic [XLEN-1:0] r_target;

   logic            w_accept, w_illegal, w_ebreak, w_ecall;
   logic            w_mret, w_fencei, w_irq, w_trap;
   logic [XLEN-1:0] w_cause, w_tval, w_epc, w_mtvec, w_mepc;

   assign w_accept  = bus.valid_i & (r_state == IDLE);
   assign w_illegal = w_accept & bus.illegal_op_i;
   assign w_ebreak  = w_accept & ~bus.illegal_op_i &
                      (bus.cflow_mode_i == CFLOW_EBREAK);
   assign w_ecall   = w_accept & ~bus.illegal_op_i &
                      (bus.cflow_mode_i == CFLOW_ECALL);
   assign w_mret    = w_accept & ~bus.illegal_op_i &
                      (bus.cflow_mode_i == CFLOW_MRET);
   assign w_fencei  = w_accept & ~bus.illegal_op_i &
                      (bus.cflow_mode_i == CFLOW_NORMAL) & bus.fencei_i;

`ifdef TRAP_CTRL_EXT_IRQ_EN
   logic w_mie, w_meie;
   assign w_irq = w_accept & ~bus.illegal_op_i &
                  (bus.cflow_mode_i == CFLOW_NORMAL) & ~bus.fencei_i &
                  w_mie & w_meie & bus.irq_ext_i;
`else
   assign w_irq = 1'b0;
`endif

   assign w_trap = w_illegal | w_ebreak | w_ecall | w_irq;
   assign w_epc  = {bus.pc_i[XLEN-1:2], 2'b00};

   // Cause terms above are already mutually exclusive by priority.
   always_comb begin
      w_cause = '0;
      w_tval  = '0;
      unique case (1'b1)
         w_illegal: begin
            w_cause = XLEN'(MCAUSE_ILLEGAL);
            w_tval  = XLEN'(bus.instr_i);
         end
         w_ebreak: begin
            w_cause = XLEN'(MCAUSE_BREAK);
            w_tval  = bus.pc_i;
         end
         w_ecall:  w_cause = XLEN'(MCAUSE_ECALL_M);
         w_irq:    w_cause = XLEN'(MCAUSE_EXT_IRQ);
         default: ;
      endcase
   end

   trap_csr_file #(
      .XLEN        (XLEN),
      .RESET_MTVEC (RESET_MTVEC)
   ) u_csr (
      .clk          (clk),
      .reset        (reset),
      .i_csr_we     (bus.csr_we_i & w_accept),
      .i_csr_addr   (bus.csr_addr_i),
      .i_csr_wdata  (bus.csr_wdata_i),
      .o_csr_rdata  (bus.csr_rdata_o),
      .i_trap       (w_trap),
      .i_trap_epc   (w_epc),
      .i_trap_cause (w_cause),
      .i_trap_tval  (w_tval),
      .i_mret       (w_mret),
`ifdef TRAP_CTRL_EXT_IRQ_EN
      .i_irq_ext    (bus.irq_ext_i),
      .o_mie        (w_mie),
      .o_meie       (w_meie),
`endif
      .o_mtvec      (w_mtvec),
      .o_mepc       (w_mepc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_redirect  <= 1'b0;
         r_flush_req <= 1'b0;
         r_target    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_redirect <= 1'b0;
               if (w_trap | w_mret) begin
                  r_state    <= REDIRECT;
                  r_redirect <= 1'b1;
                  r_target   <= w_trap ? w_mtvec : w_mepc;
               end else if (w_fencei) begin
                  r_state     <= FENCEI_WAIT;
                  r_flush_req <= 1'b1;
                  r_target    <= bus.pc_i + XLEN'(4);
               end
            end
            FENCEI_WAIT: begin
               if (bus.icache_flush_ack_i) begin
                  r_state     <= REDIRECT;
                  r_flush_req <= 1'b0;
                  r_redirect  <= 1'b1;
               end
            end
            REDIRECT: begin
               r_state    <= IDLE;
               r_redirect <= 1'b0;
            end
            default: begin
               r_state     <= IDLE;
               r_redirect  <= 1'b0;
               r_flush_req <= 1'b0;
            end
         endcase
      end
   end

   assign bus.commit_kill_o      = w_trap;
   assign bus.stall_o            = (r_state != IDLE);
   assign bus.redirect_o         = r_redirect;
   assign bus.redirect_pc_o      = r_target;
   assign bus.icache_flush_req_o = r_flush_req;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: redirect targets are queued at issue
// and popped on redirect_o; CSR state is read back through csr_rdata_o.
module tb_trap_controller;
   import trap_controller_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   trap_controller_if #(.XLEN(32)) bus();

   trap_controller #(
      .XLEN        (32),
      .RESET_MTVEC (32'h0000_0100)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] sb_q[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic idle_in();
      bus.valid_i            = 1'b0;
      bus.pc_i               = '0;
      bus.instr_i            = '0;
      bus.cflow_mode_i       = CFLOW_NORMAL;
      bus.illegal_op_i       = 1'b0;
      bus.fencei_i           = 1'b0;
      bus.csr_we_i           = 1'b0;
      bus.csr_wdata_i        = '0;
      bus.icache_flush_ack_i = 1'b0;
   endtask

   task automatic csr_chk(input string tag, input logic [11:0] a,
                          input logic [31:0] exp);
      @(negedge clk);
      bus.csr_addr_i = a;
      #1 chk(tag, bus.csr_rdata_o, exp);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.valid_i     = 1'b1;
      bus.csr_we_i    = 1'b1;
      bus.csr_addr_i  = a;
      bus.csr_wdata_i = d;
      @(posedge clk);
      #1 idle_in();
   endtask

   task automatic issue(input string tag, input logic [31:0] pc,
                        input logic [31:0] instr, input cflow_mode_t mode,
                        input logic ill, input logic fi, input logic exp_kill,
                        input logic push, input logic [31:0] tgt);
      @(negedge clk);
      bus.valid_i      = 1'b1;
      bus.pc_i         = pc;
      bus.instr_i      = instr;
      bus.cflow_mode_i = mode;
      bus.illegal_op_i = ill;
      bus.fencei_i     = fi;
      #1 chk({tag, "_kill"}, 32'(bus.commit_kill_o), 32'(exp_kill));
      if (push) sb_q.push_back(tgt);
      @(posedge clk);
      #1 idle_in();
   endtask

   task automatic wait_redirect(input string tag, input int exp_lat);
      int lat = 0;
      bit seen = 0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         if (bus.redirect_o) seen = 1;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      if (seen) begin
         chk({tag, "_sbq"}, 32'(sb_q.size()), 32'd1);
         if (sb_q.size() > 0) chk({tag, "_pc"}, bus.redirect_pc_o, sb_q.pop_front());
         @(negedge clk);
         chk({tag, "_1cyc"}, 32'(bus.redirect_o), 32'd0);
      end
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      bus.icache_flush_ack_i = 1'b1;
      @(posedge clk);
      #1 bus.icache_flush_ack_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      reset = 1'b1;
      bus.csr_addr_i = '0;
`ifdef TRAP_CTRL_EXT_IRQ_EN
      bus.irq_ext_i = 1'b0;
`endif
      idle_in();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      chk("rst_redirect", 32'(bus.redirect_o), 32'd0);
      chk("rst_stall", 32'(bus.stall_o), 32'd0);
      chk("rst_req", 32'(bus.icache_flush_req_o), 32'd0);
      chk("rst_pc", bus.redirect_pc_o, 32'd0);
      csr_chk("rst_mtvec", CSR_MTVEC, 32'h100);
      csr_chk("rst_mstatus", CSR_MSTATUS, 32'h0);
      csr_chk("rst_mepc", CSR_MEPC, 32'h0);
      csr_chk("rst_mcause", CSR_MCAUSE, 32'h0);

      issue("ecall", 32'h200, 32'h73, CFLOW_ECALL, 0, 0, 1, 1, 32'h100);
      wait_redirect("ecall", 1);
      csr_chk("ecall_mcause", CSR_MCAUSE, 32'd11);
      csr_chk("ecall_mepc", CSR_MEPC, 32'h200);
      csr_chk("ecall_mtval", CSR_MTVAL, 32'h0);
      csr_chk("ecall_mstatus", CSR_MSTATUS, 32'h0);

      wr(CSR_MSTATUS, 32'hFFFF_FFFF);
      csr_chk("mstatus_wr", CSR_MSTATUS, 32'h88);
      wr(CSR_MSTATUS, 32'h8);
      issue("ill", 32'h44, 32'hFFFF_FFFF, CFLOW_ECALL, 1, 0, 1, 1, 32'h100);
      wait_redirect("ill", 1);
      csr_chk("ill_mcause", CSR_MCAUSE, 32'd2);
      csr_chk("ill_mtval", CSR_MTVAL, 32'hFFFF_FFFF);
      csr_chk("ill_mstatus", CSR_MSTATUS, 32'h80);

      wr(CSR_MEPC, 32'h300);
      issue("mret", 32'h50, 32'h3020_0073, CFLOW_MRET, 0, 0, 0, 1, 32'h300);
      wait_redirect("mret", 1);
      csr_chk("mret_mstatus", CSR_MSTATUS, 32'h88);

      issue("ebrk", 32'h123, 32'h0010_0073, CFLOW_EBREAK, 0, 1, 1, 1, 32'h100);
      wait_redirect("ebrk", 1);
      csr_chk("ebrk_mcause", CSR_MCAUSE, 32'd3);
      csr_chk("ebrk_mtval", CSR_MTVAL, 32'h123);
      csr_chk("ebrk_mepc", CSR_MEPC, 32'h120);
      csr_chk("ebrk_mstatus", CSR_MSTATUS, 32'h80);

      issue("nop", 32'h60, 32'h1050_0073, CFLOW_NORMAL, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      chk("nop_stall", 32'(bus.stall_o), 32'd0);
      chk("nop_redirect", 32'(bus.redirect_o), 32'd0);

      issue("fencei", 32'h80, 32'h0000_100F, CFLOW_NORMAL, 0, 1, 0, 1, 32'h84);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.icache_flush_req_o && bus.stall_o) cnt++;
         if (i == 0) begin
            bus.valid_i      = 1'b1;
            bus.cflow_mode_i = CFLOW_ECALL;
            bus.pc_i         = 32'h900;
            #1 chk("busy_kill", 32'(bus.commit_kill_o), 32'd0);
         end else begin
            idle_in();
         end
      end
      bus.icache_flush_ack_i = 1'b1;
      @(posedge clk);
      #1 bus.icache_flush_ack_i = 1'b0;
      chk("fencei_req_cycles", 32'(cnt), 32'd5);
      chk("fencei_req_drop", 32'(bus.icache_flush_req_o), 32'd0);
      wait_redirect("fencei", 1);
      csr_chk("busy_mepc", CSR_MEPC, 32'h120);

      ack_pulse();
      @(negedge clk);
      chk("idle_ack_stall", 32'(bus.stall_o), 32'd0);
      chk("idle_ack_redir", 32'(bus.redirect_o), 32'd0);

      issue("fwrap", 32'hFFFF_FFFC, 32'h100F, CFLOW_NORMAL, 0, 1, 0, 1, 32'h0);
      ack_pulse();
      wait_redirect("fwrap", 1);

      wr(CSR_MTVEC, 32'h1003);
      csr_chk("mtvec_mask", CSR_MTVEC, 32'h1000);
      wr(12'h7C0, 32'hDEAD_BEEF);
      csr_chk("unimpl", 12'h7C0, 32'h0);
`ifndef TRAP_CTRL_EXT_IRQ_EN
      csr_chk("mie_absent", CSR_MIE, 32'h0);
`endif

      @(negedge clk);
      bus.valid_i      = 1'b1;
      bus.pc_i         = 32'h600;
      bus.cflow_mode_i = CFLOW_ECALL;
      bus.csr_we_i     = 1'b1;
      bus.csr_addr_i   = CSR_MEPC;
      bus.csr_wdata_i  = 32'h500;
      #1 chk("ecwr_kill", 32'(bus.commit_kill_o), 32'd1);
      sb_q.push_back(32'h1000);
      @(posedge clk);
      #1 idle_in();
      wait_redirect("ecwr", 1);
      csr_chk("ecwr_mepc", CSR_MEPC, 32'h600);

`ifdef TRAP_CTRL_EXT_IRQ_EN
      wr(CSR_MSTATUS, 32'h8);
      wr(CSR_MIE, 32'h800);
      bus.irq_ext_i = 1'b1;
      csr_chk("mip", CSR_MIP, 32'h800);
      issue("irq", 32'h10, 32'h13, CFLOW_NORMAL, 0, 0, 1, 1, 32'h1000);
      bus.irq_ext_i = 1'b0;
      wait_redirect("irq", 1);
      csr_chk("irq_mcause", CSR_MCAUSE, 32'h8000_000B);
      csr_chk("irq_mepc", CSR_MEPC, 32'h10);
`endif

      issue("frst", 32'h40, 32'h100F, CFLOW_NORMAL, 0, 1, 0, 0, 32'h0);
      repeat (2) @(negedge clk);
      chk("frst_req", 32'(bus.icache_flush_req_o), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("frst_req_drop", 32'(bus.icache_flush_req_o), 32'd0);
      chk("frst_stall", 32'(bus.stall_o), 32'd0);
      ack_pulse();
      cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.redirect_o || bus.stall_o) cnt++;
      end
      chk("frst_no_redir", 32'(cnt), 32'd0);
      csr_chk("frst_mtvec", CSR_MTVEC, 32'h100);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
